// File: rtl/mbinit_repairval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mbinit_repairval_pkg
//  Brief    : Shared LTSM definitions for the MBINIT.REPAIRVAL stage:
//             sideband message codes, state encoding, message width.
//  Revision : 1.0 - initial release
// ============================================================================
package mbinit_repairval_pkg;

    localparam int SB_MSG_W = 4;

    // REPAIRVAL sideband message codes
    localparam logic [SB_MSG_W-1:0] c_MSG_INIT_REQ    = 4'b0001;
    localparam logic [SB_MSG_W-1:0] c_MSG_INIT_RESP   = 4'b0010;
    localparam logic [SB_MSG_W-1:0] c_MSG_RESULT_REQ  = 4'b0011;
    localparam logic [SB_MSG_W-1:0] c_MSG_RESULT_RESP = 4'b0100;
    localparam logic [SB_MSG_W-1:0] c_MSG_DONE_REQ    = 4'b0101;
    localparam logic [SB_MSG_W-1:0] c_MSG_DONE_RESP   = 4'b0110;

    // Sequential binary encoding, same style as the other MBINIT stages
    typedef enum logic [3:0] {
        ST_IDLE              = 4'd0,
        ST_INIT_REQ          = 4'd1,
        ST_HANDLE_VALID      = 4'd2,
        ST_PATTERN           = 4'd3,
        ST_CHECK_BUSY_RESULT = 4'd4,
        ST_RESULT_REQ        = 4'd5,
        ST_CHECK_RESULT      = 4'd6,
        ST_CHECK_BUSY_DONE   = 4'd7,
        ST_DONE_REQ          = 4'd8,
        ST_DONE              = 4'd9,
        ST_ERROR             = 4'd10
    } repairval_state_e;

endpackage : mbinit_repairval_pkg
`default_nettype wire

// File: rtl/mbinit_repairval_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ltsm_timeout_counter
//  Brief    : Saturating LTSM stage timeout counter. Cleared by i_clear,
//             advances while i_enable is high, flags expiry once the count
//             reaches CYCLES-1 so the owning FSM lands in ERROR on cycle
//             CYCLES after leaving IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module ltsm_timeout_counter #(
    parameter int CYCLES = 8000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int             c_W    = $clog2(CYCLES) + 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(CYCLES - 1);
    localparam logic [c_W-1:0] c_MAX  = '1;

    logic [c_W-1:0] r_count_q;

    // Count up while enabled, hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count_q <= '0;
        end else if (i_enable && (r_count_q != c_MAX)) begin
            r_count_q <= r_count_q + 1'b1;
        end
    end

    assign o_expire = (r_count_q >= c_LAST);

endmodule : ltsm_timeout_counter
`default_nettype wire

// File: rtl/mbinit_repairval.sv
`default_nettype none
// ============================================================================
//  Module   : mbinit_repairval
//  Brief    : MBINIT.REPAIRVAL initiator sequencer. Runs the init / result /
//             done sideband handshake, enables the valid-lane pattern, checks
//             the partner's pass bit and raises a held end or error level.
//  Revision : 1.0 - initial release
// ============================================================================
module mbinit_repairval
    import mbinit_repairval_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8000000
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                i_REPAIRCLK_end,
    input  logic [SB_MSG_W-1:0] i_Rx_SbMessage,
    input  logic                i_msg_valid,
    input  logic                i_Busy_SideBand,
    input  logic                i_falling_edge_busy,
    input  logic                i_VAL_Pattern_done,
    input  logic                i_VAL_Result_logged,
    output logic                o_MBINIT_REPAIRVAL_Pattern_En,
    output logic                o_MBINIT_REPAIRVAL_end,
    output logic [SB_MSG_W-1:0] o_TX_SbMessage,
    output logic                o_ValidOutDatat_Module,
    output logic                o_train_error_req_repairval
);

    repairval_state_e    r_state_q, w_state_d;
    logic                r_val_pass_q, w_val_pass_d;
    logic                r_pattern_en_q, w_pattern_en_d;
    logic                r_end_q, w_end_d;
    logic [SB_MSG_W-1:0] r_tx_msg_q, w_tx_msg_d;
    logic                r_tx_valid_q, w_tx_valid_d;
    logic                r_err_q, w_err_d;
    logic                w_expire;
    logic                w_in_idle;
    logic                w_cnt_run;
    logic                w_sent;

    assign w_in_idle = (r_state_q == ST_IDLE);
    assign w_cnt_run = !w_in_idle && (r_state_q != ST_DONE) && (r_state_q != ST_ERROR);
    // A request is considered sent only when busy has really dropped
    assign w_sent    = i_falling_edge_busy && !i_Busy_SideBand;

    ltsm_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLK),
        .rst      (rst),
        .i_clear  (w_in_idle),
        .i_enable (w_cnt_run),
        .o_expire (w_expire)
    );

    // State, pass flag and registered outputs
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_val_pass_q   <= 1'b0;
            r_pattern_en_q <= 1'b0;
            r_end_q        <= 1'b0;
            r_tx_msg_q     <= '0;
            r_tx_valid_q   <= 1'b0;
            r_err_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_val_pass_q   <= w_val_pass_d;
            r_pattern_en_q <= w_pattern_en_d;
            r_end_q        <= w_end_d;
            r_tx_msg_q     <= w_tx_msg_d;
            r_tx_valid_q   <= w_tx_valid_d;
            r_err_q        <= w_err_d;
        end
    end

    // Next state: enable drop beats timeout, timeout beats normal flow
    always_comb begin
        w_state_d    = r_state_q;
        w_val_pass_d = r_val_pass_q;
        case (r_state_q)
            ST_IDLE: begin
                if (i_REPAIRCLK_end && !i_Busy_SideBand) w_state_d = ST_INIT_REQ;
            end
            ST_INIT_REQ, ST_RESULT_REQ, ST_DONE_REQ: begin
                if (w_sent) w_state_d = ST_HANDLE_VALID;
            end
            ST_HANDLE_VALID: begin
                if (i_msg_valid) begin
                    case (i_Rx_SbMessage)
                        c_MSG_INIT_RESP: w_state_d = ST_PATTERN;
                        c_MSG_RESULT_RESP: begin
                            w_val_pass_d = i_VAL_Result_logged;
                            w_state_d    = ST_CHECK_RESULT;
                        end
                        c_MSG_DONE_RESP: w_state_d = ST_DONE;
                        default:         w_state_d = r_state_q;
                    endcase
                end
            end
            ST_PATTERN: begin
                if (i_VAL_Pattern_done) w_state_d = ST_CHECK_BUSY_RESULT;
            end
            ST_CHECK_BUSY_RESULT: begin
                if (!i_Busy_SideBand) w_state_d = ST_RESULT_REQ;
            end
            ST_CHECK_RESULT: begin
                w_state_d = r_val_pass_q ? ST_CHECK_BUSY_DONE : ST_ERROR;
            end
            ST_CHECK_BUSY_DONE: begin
                if (!i_Busy_SideBand) w_state_d = ST_DONE_REQ;
            end
            ST_DONE, ST_ERROR: begin
                w_state_d = r_state_q;
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_cnt_run && w_expire) w_state_d = ST_ERROR;
        if (!w_in_idle && !i_REPAIRCLK_end) w_state_d = ST_IDLE;
    end

    // Output decode from next state so outputs align with the state register
    always_comb begin
        w_pattern_en_d = 1'b0;
        w_end_d        = 1'b0;
        w_tx_msg_d     = '0;
        w_tx_valid_d   = 1'b0;
        w_err_d        = 1'b0;
        case (w_state_d)
            ST_INIT_REQ: begin
                w_tx_valid_d = 1'b1;
                w_tx_msg_d   = c_MSG_INIT_REQ;
            end
            ST_RESULT_REQ: begin
                w_tx_valid_d = 1'b1;
                w_tx_msg_d   = c_MSG_RESULT_REQ;
            end
            ST_DONE_REQ: begin
                w_tx_valid_d = 1'b1;
                w_tx_msg_d   = c_MSG_DONE_REQ;
            end
            ST_PATTERN: w_pattern_en_d = 1'b1;
            ST_DONE:    w_end_d        = 1'b1;
            ST_ERROR:   w_err_d        = 1'b1;
            default:    w_end_d        = 1'b0;
        endcase
    end

    assign o_MBINIT_REPAIRVAL_Pattern_En = r_pattern_en_q;
    assign o_MBINIT_REPAIRVAL_end        = r_end_q;
    assign o_TX_SbMessage                = r_tx_msg_q;
    assign o_ValidOutDatat_Module        = r_tx_valid_q;
    assign o_train_error_req_repairval   = r_err_q;

endmodule : mbinit_repairval
`default_nettype wire

// File: tb/tb_mbinit_repairval.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbinit_repairval
//  Brief    : Directed self-checking bench for mbinit_repairval. Outputs are
//             packed as {pat_en, end, valid, err, tx[3:0]} for comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mbinit_repairval;

    logic       CLK = 1'b0;
    logic       rst;
    logic       i_REPAIRCLK_end;
    logic [3:0] i_Rx_SbMessage;
    logic       i_msg_valid;
    logic       i_Busy_SideBand;
    logic       i_falling_edge_busy;
    logic       i_VAL_Pattern_done;
    logic       i_VAL_Result_logged;
    logic       o_pat;
    logic       o_end;
    logic [3:0] o_tx;
    logic       o_vld;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // Expected packed output vectors {pat, end, vld, err, tx}
    localparam logic [7:0] c_ZERO   = 8'b0000_0000;
    localparam logic [7:0] c_INIT   = 8'b0010_0001;
    localparam logic [7:0] c_RESULT = 8'b0010_0011;
    localparam logic [7:0] c_DONEQ  = 8'b0010_0101;
    localparam logic [7:0] c_PAT    = 8'b1000_0000;
    localparam logic [7:0] c_END    = 8'b0100_0000;
    localparam logic [7:0] c_ERR    = 8'b0001_0000;

    mbinit_repairval #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLK                           (CLK),
        .rst                           (rst),
        .i_REPAIRCLK_end               (i_REPAIRCLK_end),
        .i_Rx_SbMessage                (i_Rx_SbMessage),
        .i_msg_valid                   (i_msg_valid),
        .i_Busy_SideBand               (i_Busy_SideBand),
        .i_falling_edge_busy           (i_falling_edge_busy),
        .i_VAL_Pattern_done            (i_VAL_Pattern_done),
        .i_VAL_Result_logged           (i_VAL_Result_logged),
        .o_MBINIT_REPAIRVAL_Pattern_En (o_pat),
        .o_MBINIT_REPAIRVAL_end        (o_end),
        .o_TX_SbMessage                (o_tx),
        .o_ValidOutDatat_Module        (o_vld),
        .o_train_error_req_repairval   (o_err)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {o_pat, o_end, o_vld, o_err, o_tx};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One-cycle input pulse helpers: set, clock, clear
    task automatic fe_pulse();
        i_falling_edge_busy = 1'b1;
        step();
        i_falling_edge_busy = 1'b0;
    endtask

    task automatic rx(input logic [3:0] code, input logic res);
        i_Rx_SbMessage      = code;
        i_VAL_Result_logged = res;
        i_msg_valid         = 1'b1;
        step();
        i_msg_valid         = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_REPAIRCLK_end = 1'b0; i_Rx_SbMessage = 4'b0;
        i_msg_valid = 1'b0; i_Busy_SideBand = 1'b0; i_falling_edge_busy = 1'b0;
        i_VAL_Pattern_done = 1'b0; i_VAL_Result_logged = 1'b0;
        step(); step();
        chk("reset", c_ZERO);
        rst = 1'b0;
        step();
        chk("idle_no_enable", c_ZERO);

        // ---------------- nominal pass ----------------
        i_REPAIRCLK_end = 1'b1;
        step();
        chk("init_req", c_INIT);
        i_Busy_SideBand = 1'b1;
        step();
        chk("init_req_hold_busy", c_INIT);
        i_Busy_SideBand = 1'b0;
        fe_pulse();
        chk("init_released", c_ZERO);
        rx(4'b0010, 1'b0);
        chk("pattern_en", c_PAT);
        step();
        chk("pattern_en_hold", c_PAT);
        i_VAL_Pattern_done = 1'b1;
        step();
        i_VAL_Pattern_done = 1'b0;
        chk("pattern_done", c_ZERO);
        step();
        chk("result_req", c_RESULT);
        fe_pulse();
        chk("result_released", c_ZERO);
        // stray code without valid, then an unknown code with valid: both ignored
        i_Rx_SbMessage = 4'b0110;
        step();
        chk("stray_no_valid", c_ZERO);
        rx(4'b0111, 1'b1);
        chk("stray_unknown", c_ZERO);
        rx(4'b0100, 1'b1);
        chk("check_result", c_ZERO);
        step();
        chk("check_busy_done", c_ZERO);
        step();
        chk("done_req", c_DONEQ);
        fe_pulse();
        chk("done_released", c_ZERO);
        rx(4'b0110, 1'b0);
        chk("end_set", c_END);
        step();
        chk("end_held", c_END);
        i_REPAIRCLK_end = 1'b0;
        step();
        chk("end_drop", c_ZERO);

        // ---------------- failed valid lane ----------------
        i_REPAIRCLK_end = 1'b1;
        step();
        chk("f_init_req", c_INIT);
        fe_pulse();
        rx(4'b0010, 1'b0);
        i_VAL_Pattern_done = 1'b1;
        step();
        i_VAL_Pattern_done = 1'b0;
        step();
        chk("f_result_req", c_RESULT);
        fe_pulse();
        rx(4'b0100, 1'b0);
        chk("f_check_result", c_ZERO);
        step();
        chk("f_error", c_ERR);
        step();
        chk("f_error_held", c_ERR);
        i_REPAIRCLK_end = 1'b0;
        step();
        chk("f_error_drop", c_ZERO);

        // ---------------- abort mid-pattern and restart ----------------
        i_REPAIRCLK_end = 1'b1;
        step();
        fe_pulse();
        rx(4'b0010, 1'b0);
        chk("a_pattern", c_PAT);
        i_REPAIRCLK_end = 1'b0;
        step();
        chk("a_abort", c_ZERO);
        i_REPAIRCLK_end = 1'b1;
        step();
        chk("a_restart", c_INIT);

        // ---------------- busy gating of falling-edge pulse ----------------
        i_Busy_SideBand = 1'b1;
        fe_pulse();
        chk("g_pulse_while_busy", c_INIT);
        i_Busy_SideBand = 1'b0;
        step();
        chk("g_no_pulse", c_INIT);
        fe_pulse();
        chk("g_clean_pulse", c_ZERO);

        // ---------------- msg_valid together with enable drop ----------------
        i_REPAIRCLK_end = 1'b0;
        rx(4'b0010, 1'b0);
        chk("s_msg_and_drop", c_ZERO);
        i_REPAIRCLK_end = 1'b1;
        step();
        chk("s_restart", c_INIT);

        // ---------------- reset mid-sequence ----------------
        fe_pulse();
        rx(4'b0010, 1'b0);
        chk("r_pattern", c_PAT);
        rst = 1'b1;
        step();
        chk("r_reset_mid", c_ZERO);
        rst = 1'b0;
        i_REPAIRCLK_end = 1'b0;
        step();

        // ---------------- timeout: ERROR on cycle 100 after leaving IDLE ----------------
        i_REPAIRCLK_end = 1'b1;
        step();
        chk("t_init_req", c_INIT);
        for (int i = 1; i < 100; i++) step();
        chk("t_cycle99", c_INIT);
        step();
        chk("t_error_100", c_ERR);
        i_REPAIRCLK_end = 1'b0;
        step();
        chk("t_error_drop", c_ZERO);

        // ---------------- enable drop beats timeout on the same cycle ----------------
        i_REPAIRCLK_end = 1'b1;
        step();
        for (int i = 1; i < 100; i++) step();
        chk("p_cycle99", c_INIT);
        i_REPAIRCLK_end = 1'b0;
        step();
        chk("p_drop_over_timeout", c_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mbinit_repairval
`default_nettype wire

// File: doc/mbinit_repairval.md
# mbinit_repairval

MBINIT.REPAIRVAL initiator sequencer for the UCIe PHY LTSM.
- Runs after MBINIT.REPAIRCLK completes.
- Exchanges the REPAIRVAL sideband handshake with the partner and triggers the valid-lane training pattern.
- Checks the logged valid-lane result, then raises a level-held end flag. That flag feeds `i_REPAIRVAL_end` of the downstream REVERSALMB stage.
- Reports a training error on a failed valid lane or on the handshake timeout.

## Interface
- `TIMEOUT_CYCLES`, default 8000000: cycles from leaving IDLE before a training error is declared (8 ms at 1 GHz).
- `CLK` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_REPAIRCLK_end` input 1: level enable; upstream REPAIRCLK done. Low at any time aborts to IDLE.
- `i_Rx_SbMessage` input 4: decoded received sideband message.
- `i_msg_valid` input 1: `i_Rx_SbMessage` is valid this cycle.
- `i_Busy_SideBand` input 1: sideband TX is busy.
- `i_falling_edge_busy` input 1: one-cycle pulse when busy deasserts.
- `i_VAL_Pattern_done` input 1: pulse; valid-lane pattern burst finished.
- `i_VAL_Result_logged` input 1: partner's valid-lane pass bit, carried with result_resp.
- `o_MBINIT_REPAIRVAL_Pattern_En` output 1: enable for the valid-lane pattern generator.
- `o_MBINIT_REPAIRVAL_end` output 1: level; stage complete. Drives REVERSALMB.
- `o_TX_SbMessage` output 4: sideband message to send.
- `o_ValidOutDatat_Module` output 1: `o_TX_SbMessage` is valid.
- `o_train_error_req_repairval` output 1: level; training error request to the LTSM.

## Operation
- Message codes:
  - init_req=0001, init_resp=0010
  - result_req=0011, result_resp=0100
  - done_req=0101, done_resp=0110
- States and transitions:
  - IDLE: go to INIT_REQ when `i_REPAIRCLK_end` is high and busy is low.
  - INIT_REQ: go to HANDLE_VALID on falling-edge pulse with busy low.
  - HANDLE_VALID: on `i_msg_valid`:
    - init_resp goes to PATTERN.
    - result_resp latches `i_VAL_Result_logged` into `val_pass` and goes to CHECK_RESULT.
    - done_resp goes to DONE.
    - Any other code is ignored.
  - PATTERN: go to CHECK_BUSY_RESULT on `i_VAL_Pattern_done`.
  - CHECK_BUSY_RESULT: go to RESULT_REQ when busy is low.
  - RESULT_REQ: go to HANDLE_VALID on falling-edge pulse with busy low.
  - CHECK_RESULT: go to CHECK_BUSY_DONE if `val_pass`=1, else go to ERROR.
  - CHECK_BUSY_DONE: go to DONE_REQ when busy is low.
  - DONE_REQ: go to HANDLE_VALID on falling-edge pulse with busy low.
  - DONE: hold.
  - ERROR: hold.
- Every non-IDLE state returns to IDLE when `i_REPAIRCLK_end` is low. This has priority over all other conditions, including timeout.
- Timeout counter:
  - Width is `$clog2(TIMEOUT_CYCLES)+1`. Cleared in IDLE.
  - Increments each cycle in any state other than IDLE, DONE and ERROR. Saturates.
  - When it reaches `TIMEOUT_CYCLES-1`, the next state is ERROR. This overrides the normal transition.
- Outputs are registered and decoded from NS. Each cycle all outputs default to 0, then by NS:
  - INIT_REQ, RESULT_REQ, DONE_REQ: valid=1, with the matching message code.
  - PATTERN: `Pattern_En`=1.
  - DONE: `end`=1.
  - ERROR: `train_error_req`=1.
- An unused state encoding goes to IDLE.

## Timing
- Reset: every output is 0, CS=IDLE, counter=0, `val_pass`=0.
- Outputs are asserted in the same cycle that CS becomes the target state: one clock after the NS condition is sampled.
- IDLE to `o_ValidOutDatat_Module` high: 1 cycle.
- Request valid/message stays high for the whole time CS holds the *_REQ state. It drops the cycle after the falling-edge pulse is sampled.
- `o_MBINIT_REPAIRVAL_end` and `o_train_error_req_repairval` are held levels. Each drops 1 cycle after `i_REPAIRCLK_end` falls.
- A falling-edge pulse while busy is still high is ignored.
- Simultaneous `i_msg_valid` and an enable drop: go to IDLE.
- `rst` high mid-sequence: all outputs are 0 on the next edge.

## Structure
- Shared LTSM package holds:
  - the REPAIRVAL message-code localparams;
  - a state enum, with the same encoding style as the other MBINIT stages;
  - a `SB_MSG_W`=4 constant.
- One natural sub-module: `ltsm_timeout_counter`. It is parameterized on cycles, with clear/enable inputs and an expire output, and is reusable by the other MBINIT stages.

## Test plan
- **Nominal pass:**
  - Stimulus: enable high; busy pulses after each request; responses 0010, then 0100 with result=1, then 0110.
  - Required: TX codes 0001, 0011, 0101 in order; `Pattern_En` high until `pattern_done`; `end`=1 and held.
- **Failed valid lane:**
  - Stimulus: result_resp with `i_VAL_Result_logged`=0.
  - Required: `train_error_req`=1 two cycles after the message; `end` stays 0.
- **Abort mid-pattern:**
  - Stimulus: drop `i_REPAIRCLK_end` during PATTERN.
  - Required: next cycle all outputs 0, CS=IDLE. Re-raising the enable restarts with 0001.
- **Timeout:**
  - Setup: `TIMEOUT_CYCLES`=100.
  - Stimulus: no init_resp is ever sent.
  - Required: ERROR at cycle 100 after leaving IDLE; `train_error_req`=1.
- **Busy gating:**
  - Stimulus: falling-edge pulse while busy=1, then a clean pulse.
  - Required: the request stays asserted through the first pulse and is released only on the second.
- **Stray message:**
  - Stimulus: 0110 received in HANDLE_VALID before result_resp, with `i_msg_valid`=0.
  - Required: no state change.
